// File: rtl/vrc_irq_timer.sv
// VRC4/VRC6 IRQ counter with scanline prescaler and save-state access; all state updates on negedge m2.
// Latency: irq is registered, so it changes one m2 falling edge after its cause. Backpressure: none (CPU bus slave).
module vrc_irq_timer #(
  parameter logic [15:0] REG_BASE = 16'hF000,
  parameter int          PRE_LOAD = 341,
  parameter int          PRE_STEP = 3,
  parameter logic [7:0]  SST_BASE = 8'd32
) (
  input  logic        m2,
  input  logic        map_rst,
  input  logic        cpu_rw,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  cpu_data,
  input  logic        sst_act,
  input  logic        sst_we,
  input  logic [7:0]  sst_addr,
  input  logic [7:0]  sst_dato,
  output logic        irq,
  output logic [7:0]  ss_dout
);

  localparam logic [8:0] PRE_LD   = 9'(PRE_LOAD);
  localparam logic [8:0] PRE_ST   = 9'(PRE_STEP);
  localparam logic [8:0] PRE_WRAP = 9'(PRE_LOAD - PRE_STEP);

  logic [7:0] latch;
  logic [7:0] cnt;
  logic [8:0] pre;
  logic       ctl_a, ctl_e, ctl_m, irq_pend;

  logic       wr_lo, wr_hi, wr_ctl, wr_ack;
  logic       tick;
  logic [8:0] pre_nxt;
  logic [7:0] sst_idx;

  assign wr_lo   = !cpu_rw && (reg_addr == REG_BASE);
  assign wr_hi   = !cpu_rw && (reg_addr == REG_BASE + 16'd1);
  assign wr_ctl  = !cpu_rw && (reg_addr == REG_BASE + 16'd2);
  assign wr_ack  = !cpu_rw && (reg_addr == REG_BASE + 16'd3);
  assign sst_idx = sst_addr - SST_BASE;
  assign irq     = irq_pend;

  // Cycle mode ticks every edge and leaves the prescaler alone.
  always_comb begin
    tick    = 1'b0;
    pre_nxt = pre;
    if (ctl_m) begin
      tick = 1'b1;
    end else if (pre < PRE_ST) begin
      tick    = 1'b1;
      pre_nxt = pre + PRE_WRAP;
    end else begin
      pre_nxt = pre - PRE_ST;
    end
  end

  always_ff @(negedge m2) begin
    if (sst_act) begin
      if (sst_we) begin
        case (sst_idx)
          8'd0: latch <= sst_dato;
          8'd1: cnt   <= sst_dato;
          8'd2: begin
            ctl_a    <= sst_dato[0];
            ctl_e    <= sst_dato[1];
            ctl_m    <= sst_dato[2];
            irq_pend <= sst_dato[3];
          end
          8'd3: pre[7:0] <= sst_dato;
          8'd4: pre[8]   <= sst_dato[0];
          default: ;
        endcase
      end
    end else if (map_rst) begin
      latch    <= 8'h00;
      cnt      <= 8'h00;
      pre      <= PRE_LD;
      ctl_a    <= 1'b0;
      ctl_e    <= 1'b0;
      ctl_m    <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_lo) latch[3:0] <= cpu_data[3:0];
      if (wr_hi) latch[7:4] <= cpu_data[3:0];
      // Control and ack writes pre-empt any tick on the same edge; reloads see the old latch.
      if (wr_ctl) begin
        ctl_a    <= cpu_data[0];
        ctl_e    <= cpu_data[1];
        ctl_m    <= cpu_data[2];
        irq_pend <= 1'b0;
        pre      <= PRE_LD;
        if (cpu_data[1]) cnt <= latch;
      end else if (wr_ack) begin
        ctl_e    <= ctl_a;
        irq_pend <= 1'b0;
      end else if (ctl_e) begin
        pre <= pre_nxt;
        if (tick) begin
          if (cnt == 8'hFF) begin
            cnt      <= latch;
            irq_pend <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      end
    end
  end

  always_comb begin
    ss_dout = 8'hFF;
    case (sst_idx)
      8'd0:    ss_dout = latch;
      8'd1:    ss_dout = cnt;
      8'd2:    ss_dout = {4'b0000, irq_pend, ctl_m, ctl_e, ctl_a};
      8'd3:    ss_dout = pre[7:0];
      8'd4:    ss_dout = {7'b0000000, pre[8]};
      default: ss_dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_vrc_irq_timer.sv
// Directed bench for vrc_irq_timer: CPU writes, both count modes, ack, reset and save-state paths.
module tb_vrc_irq_timer;

  logic        m2 = 1'b1;
  logic        map_rst, cpu_rw, sst_act, sst_we, irq;
  logic [15:0] reg_addr;
  logic [7:0]  cpu_data, sst_addr, sst_dato, ss_dout;
  int          total = 0;
  int          bad = 0;

  vrc_irq_timer dut (
    .m2(m2), .map_rst(map_rst), .cpu_rw(cpu_rw), .reg_addr(reg_addr),
    .cpu_data(cpu_data), .sst_act(sst_act), .sst_we(sst_we),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .irq(irq), .ss_dout(ss_dout)
  );

  always #5 m2 = ~m2;

  task automatic edge_();
    @(negedge m2);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) edge_();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_rw = 1'b0; reg_addr = a; cpu_data = d;
    edge_();
    cpu_rw = 1'b1; reg_addr = 16'h0000; cpu_data = 8'h00;
  endtask

  task automatic sw(input logic [7:0] idx, input logic [7:0] d);
    sst_act = 1'b1; sst_we = 1'b1; sst_addr = 8'd32 + idx; sst_dato = d;
    edge_();
    sst_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ss(input string tag, input logic [7:0] idx, input logic [7:0] exp);
    sst_addr = 8'd32 + idx;
    #1;
    chk(tag, ss_dout, exp);
  endtask

  initial begin
    map_rst = 1'b1; cpu_rw = 1'b1; reg_addr = 16'h0000; cpu_data = 8'h00;
    sst_act = 1'b0; sst_we = 1'b0; sst_addr = 8'd0; sst_dato = 8'h00;
    run(2);
    map_rst = 1'b0;
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk_ss("rst_latch", 0, 8'h00);
    chk_ss("rst_cnt", 1, 8'h00);
    chk_ss("rst_ctl", 2, 8'h00);
    chk_ss("rst_pre_lo", 3, 8'h55);
    chk_ss("rst_pre_hi", 4, 8'h01);

    // Cycle mode from latch FD: overflow on the third edge
    wr(16'hF000, 8'h0D); wr(16'hF001, 8'h0F); wr(16'hF002, 8'h06);
    chk_ss("c_load_cnt", 1, 8'hFD);
    chk_ss("c_load_ctl", 2, 8'h06);
    run(2);
    chk("c_irq_e2", {7'd0, irq}, 8'h00);
    chk_ss("c_cnt_e2", 1, 8'hFF);
    run(1);
    chk("c_irq_e3", {7'd0, irq}, 8'h01);
    chk_ss("c_cnt_e3", 1, 8'hFD);

    // Ack with ctl_a=1 keeps counting; full 256-tick period with latch 00
    wr(16'hF000, 8'h00); wr(16'hF001, 8'h00); wr(16'hF002, 8'h07);
    chk("a_irq_clr", {7'd0, irq}, 8'h00);
    run(256);
    chk("a_irq_set", {7'd0, irq}, 8'h01);
    chk_ss("a_cnt_reload", 1, 8'h00);
    wr(16'hF003, 8'h00);
    chk("a_ack_irq", {7'd0, irq}, 8'h00);
    chk_ss("a_ack_ctl", 2, 8'h07);
    chk_ss("a_ack_cnt", 1, 8'h00);
    run(255);
    chk("a_irq_255", {7'd0, irq}, 8'h00);
    chk_ss("a_cnt_255", 1, 8'hFF);
    run(1);
    chk("a_irq_256", {7'd0, irq}, 8'h01);

    // Ack with ctl_a=0 disables counting
    wr(16'hF002, 8'h06);
    run(256);
    chk("n_irq_set", {7'd0, irq}, 8'h01);
    wr(16'hF003, 8'h00);
    chk("n_ack_irq", {7'd0, irq}, 8'h00);
    chk_ss("n_ack_ctl", 2, 8'h04);
    run(1000);
    chk("n_frozen_irq", {7'd0, irq}, 8'h00);
    chk_ss("n_frozen_cnt", 1, 8'h00);
    wr(16'hF000, 8'h0F); wr(16'hF001, 8'h0F); wr(16'hF002, 8'h06);
    chk_ss("n_cnt_ff", 1, 8'hFF);
    wr(16'hF002, 8'h06);
    chk("n_ctl_on_ovf_irq", {7'd0, irq}, 8'h00);
    chk_ss("n_ctl_on_ovf_cnt", 1, 8'hFF);
    run(1);
    chk("n_ovf_after", {7'd0, irq}, 8'h01);

    // Scanline mode: first tick on the 114th enabled edge
    wr(16'hF002, 8'h02);
    chk("s_irq_clr", {7'd0, irq}, 8'h00);
    run(113);
    chk("s_irq_113", {7'd0, irq}, 8'h00);
    chk_ss("s_pre_113", 3, 8'h02);
    run(1);
    chk("s_irq_114", {7'd0, irq}, 8'h01);
    chk_ss("s_cnt_114", 1, 8'hFF);
    chk_ss("s_pre_lo_114", 3, 8'h54);
    chk_ss("s_pre_hi_114", 4, 8'h01);

    // Reset mid-count with cnt=80, pre=100, irq pending
    sw(0, 8'h33); sw(1, 8'h80); sw(2, 8'h0A); sw(3, 8'h64); sw(4, 8'h00);
    sst_act = 1'b0;
    run(1);
    chk("r_pre_run", {7'd0, irq}, 8'h01);
    chk_ss("r_pre_dec", 3, 8'h61);
    map_rst = 1'b1;
    run(1);
    map_rst = 1'b0;
    chk("r_irq", {7'd0, irq}, 8'h00);
    chk_ss("r_latch", 0, 8'h00);
    chk_ss("r_cnt", 1, 8'h00);
    chk_ss("r_ctl", 2, 8'h00);
    chk_ss("r_pre_lo", 3, 8'h55);
    chk_ss("r_pre_hi", 4, 8'h01);

    // Save-state load; CPU write during sst_act must be ignored
    sw(0, 8'h40); sw(1, 8'hFE); sw(2, 8'h07); sw(3, 8'h05); sw(4, 8'h00);
    cpu_rw = 1'b0; reg_addr = 16'hF000; cpu_data = 8'h09;
    edge_();
    cpu_rw = 1'b1; reg_addr = 16'h0000;
    sst_act = 1'b0;
    chk_ss("ss_latch", 0, 8'h40);
    chk_ss("ss_cnt", 1, 8'hFE);
    chk_ss("ss_ctl", 2, 8'h07);
    chk_ss("ss_pre_lo", 3, 8'h05);
    chk_ss("ss_pre_hi", 4, 8'h00);
    chk_ss("ss_oor_hi", 5, 8'hFF);
    sst_addr = 8'd31;
    #1;
    chk("ss_oor_lo", ss_dout, 8'hFF);
    run(1);
    chk("ss_irq_e1", {7'd0, irq}, 8'h00);
    run(1);
    chk("ss_irq_e2", {7'd0, irq}, 8'h01);
    chk_ss("ss_cnt_e2", 1, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
